// File: rtl/ex_operand_stage_pkg.sv
// rtl/ex_operand_stage_pkg.sv - shared CPU constants, forwarding encoding and ID/EX register layout
package ex_operand_stage_pkg;

  localparam logic [4:0] ALU_AND = 5'd0;
  localparam logic [4:0] ALU_OR  = 5'd1;
  localparam logic [4:0] ALU_ADD = 5'd2;
  localparam logic [4:0] ALU_SUB = 5'd6;
  localparam logic [4:0] ALU_SLL = 5'd8;
  localparam logic [4:0] ALU_SRA = 5'd9;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_WB  = 2'd1,
    FWD_EXM = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  alu_control;
    logic        alu_src_imm;
    logic        is_shift;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  shamt;
  } idex_t;

  function automatic idex_t idex_bubble();
    idex_t b;
    b = '0;
    b.alu_control = ALU_ADD;
    return b;
  endfunction

endpackage

// File: rtl/ex_operand_stage_forward_unit.sv
// rtl/ex_operand_stage_forward_unit.sv - forwarding priority select for one operand
module forward_unit
  import ex_operand_stage_pkg::*;
(
  input  logic [4:0]  reg_num,
  input  logic [31:0] reg_val,
  input  logic        exm_reg_write,
  input  logic [4:0]  exm_rd,
  input  logic [31:0] exm_result,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_result,
  output logic [31:0] value
);

  fwd_sel_t sel;

  // EX/MEM is the younger producer, so it beats MEM/WB; r0 is hardwired zero
  always_comb begin
    sel = FWD_REG;
    if (reg_num != 5'd0 && exm_reg_write && exm_rd == reg_num)
      sel = FWD_EXM;
    else if (reg_num != 5'd0 && wb_reg_write && wb_rd == reg_num)
      sel = FWD_WB;
  end

  always_comb begin
    case (sel)
      FWD_EXM: value = exm_result;
      FWD_WB:  value = wb_result;
      default: value = reg_val;
    endcase
  end

endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX pipeline register with operand forwarding and load-use detect
module ex_operand_stage
  import ex_operand_stage_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               id_valid,
  input  logic [31:0]        id_rs_val,
  input  logic [31:0]        id_rt_val,
  input  logic [31:0]        id_imm,
  input  logic [4:0]         id_shamt,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic [4:0]         id_rd,
  input  logic [4:0]         id_alu_control,
  input  logic               id_alu_src_imm,
  input  logic               id_is_shift,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               stall,
  input  logic               flush,
  input  logic               exm_reg_write,
  input  logic [4:0]         exm_rd,
  input  logic [31:0]        exm_result,
  input  logic               wb_reg_write,
  input  logic [4:0]         wb_rd,
  input  logic [31:0]        wb_result,
  output logic signed [31:0] src_a,
  output logic signed [31:0] src_b,
  output logic [4:0]         sig_alu_control,
  output logic               ex_valid,
  output logic [4:0]         ex_rd,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic [31:0]        ex_store_data,
  output logic               load_use_hazard
);

  idex_t r;
  idex_t d;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;

  // An invalid decode slot is loaded as a full bubble so nothing stale leaks downstream
  always_comb begin
    d = r;
    if (flush) begin
      d = idex_bubble();
    end else if (!stall) begin
      if (id_valid) begin
        d.valid       = 1'b1;
        d.rs          = id_rs;
        d.rt          = id_rt;
        d.rd          = id_rd;
        d.alu_control = id_alu_control;
        d.alu_src_imm = id_alu_src_imm;
        d.is_shift    = id_is_shift;
        d.reg_write   = id_reg_write;
        d.mem_read    = id_mem_read;
        d.mem_write   = id_mem_write;
        d.rs_val      = id_rs_val;
        d.rt_val      = id_rt_val;
        d.imm         = id_imm;
        d.shamt       = id_shamt;
      end else begin
        d = idex_bubble();
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r <= idex_bubble();
    else          r <= d;
  end

  forward_unit u_fwd_rs (
    .reg_num(r.rs), .reg_val(r.rs_val),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .value(fwd_rs)
  );

  forward_unit u_fwd_rt (
    .reg_num(r.rt), .reg_val(r.rt_val),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .value(fwd_rt)
  );

  // Shifts take the value to shift from rt and the amount from shamt
  always_comb begin
    src_a = r.is_shift ? fwd_rt : fwd_rs;
    if (r.is_shift)         src_b = {27'b0, r.shamt};
    else if (r.alu_src_imm) src_b = r.imm;
    else                    src_b = fwd_rt;
  end

  assign sig_alu_control = r.alu_control;
  assign ex_valid        = r.valid;
  assign ex_rd           = r.rd;
  assign ex_reg_write    = r.reg_write;
  assign ex_mem_read     = r.mem_read;
  assign ex_mem_write    = r.mem_write;
  assign ex_store_data   = fwd_rt;

  assign load_use_hazard = r.valid && r.mem_read && (r.rd != 5'd0) &&
                           ((r.rd == id_rs) || (r.rd == id_rt)) && id_valid;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - randomized self-checking bench for ex_operand_stage
module tb_ex_operand_stage;
  import ex_operand_stage_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic id_valid, id_alu_src_imm, id_is_shift, id_reg_write, id_mem_read, id_mem_write;
  logic [31:0] id_rs_val, id_rt_val, id_imm;
  logic [4:0] id_shamt, id_rs, id_rt, id_rd, id_alu_control;
  logic stall, flush;
  logic exm_reg_write, wb_reg_write;
  logic [4:0] exm_rd, wb_rd;
  logic [31:0] exm_result, wb_result;
  logic signed [31:0] src_a, src_b;
  logic [4:0] sig_alu_control, ex_rd;
  logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;
  logic [31:0] ex_store_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_control(id_alu_control), .id_alu_src_imm(id_alu_src_imm), .id_is_shift(id_is_shift),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .stall(stall), .flush(flush),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .src_a(src_a), .src_b(src_b), .sig_alu_control(sig_alu_control),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data), .load_use_hazard(load_use_hazard)
  );

  // Reference: the instruction currently sitting in EX, as a plain record
  typedef struct {
    bit valid;
    bit [4:0] rs, rt, rd, alu, shamt;
    bit imm_sel, shift, rw, mr, mw;
    bit [31:0] rs_val, rt_val, imm;
  } ref_t;

  ref_t m;
  ref_t nxt;

  function automatic ref_t bubble();
    ref_t b;
    b = '{default: 0};
    b.alu = ALU_ADD;
    return b;
  endfunction

  function automatic bit [31:0] fwd(bit [4:0] r, bit [31:0] v);
    if (r == 0) return v;
    if (exm_reg_write && exm_rd == r) return exm_result;
    if (wb_reg_write && wb_rd == r) return wb_result;
    return v;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    bit [31:0] a_rs, a_rt, ea, eb;
    bit lu;
    a_rs = fwd(m.rs, m.rs_val);
    a_rt = fwd(m.rt, m.rt_val);
    ea = m.shift ? a_rt : a_rs;
    eb = m.shift ? {27'b0, m.shamt} : (m.imm_sel ? m.imm : a_rt);
    lu = m.valid && m.mr && m.rd != 0 && (m.rd == id_rs || m.rd == id_rt) && id_valid;
    check({tag, ".src_a"}, src_a, ea);
    check({tag, ".src_b"}, src_b, eb);
    check({tag, ".store"}, ex_store_data, a_rt);
    check({tag, ".alu"}, {27'b0, sig_alu_control}, {27'b0, m.alu});
    check({tag, ".ctl"}, {27'b0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard},
          {27'b0, m.valid, m.rw, m.mr, m.mw, lu});
    check({tag, ".rd"}, {27'b0, ex_rd}, {27'b0, m.rd});
  endtask

  task automatic clock();
    if (flush) nxt = bubble();
    else if (stall) nxt = m;
    else if (!id_valid) nxt = bubble();
    else begin
      nxt.valid = 1; nxt.rs = id_rs; nxt.rt = id_rt; nxt.rd = id_rd;
      nxt.alu = id_alu_control; nxt.shamt = id_shamt; nxt.imm_sel = id_alu_src_imm;
      nxt.shift = id_is_shift; nxt.rw = id_reg_write; nxt.mr = id_mem_read;
      nxt.mw = id_mem_write; nxt.rs_val = id_rs_val; nxt.rt_val = id_rt_val; nxt.imm = id_imm;
    end
    @(posedge clk);
    #1;
    m = nxt;
  endtask

  task automatic set_id(bit v, bit [4:0] rs, bit [4:0] rt, bit [4:0] rd, bit [31:0] rsv,
                        bit [31:0] rtv, bit [31:0] imm, bit [4:0] sh, bit [4:0] alu,
                        bit isel, bit shf, bit rw, bit mr, bit mw);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_val = rsv; id_rt_val = rtv;
    id_imm = imm; id_shamt = sh; id_alu_control = alu; id_alu_src_imm = isel;
    id_is_shift = shf; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic set_fwd(bit erw, bit [4:0] erd, bit [31:0] eres, bit wrw, bit [4:0] wrd, bit [31:0] wres);
    exm_reg_write = erw; exm_rd = erd; exm_result = eres;
    wb_reg_write = wrw; wb_rd = wrd; wb_result = wres;
  endtask

  task automatic reset_pulse(string tag);
    reset_n = 1'b0;
    #1;
    m = bubble();
    check_all(tag);
    check({tag, ".valid"}, {31'b0, ex_valid}, 32'd0);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] held_a, held_b;
    reset_n = 1'b0;
    stall = 0; flush = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    m = bubble();
    #12;
    check("rst.valid", {31'b0, ex_valid}, 32'd0);
    check("rst.rw", {31'b0, ex_reg_write}, 32'd0);
    check("rst.alu", {27'b0, sig_alu_control}, {27'b0, ALU_ADD});
    check("rst.src_a", src_a, 32'd0);
    check("rst.src_b", src_b, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_all("rst");

    // EX/MEM wins over MEM/WB for rs; rt keeps register value
    set_id(1, 3, 4, 5, 5, 7, 0, 0, ALU_ADD, 0, 0, 1, 0, 0);
    clock();
    set_fwd(1, 3, 100, 1, 3, 200);
    #1;
    check("prio.src_a", src_a, 32'd100);
    check("prio.src_b", src_b, 32'd7);
    check_all("prio");

    // r0 never forwarded
    set_id(1, 0, 4, 5, 9, 7, 0, 0, ALU_ADD, 0, 0, 1, 0, 0);
    clock();
    set_fwd(1, 0, 55, 1, 0, 66);
    #1;
    check("r0.src_a", src_a, 32'd9);
    check_all("r0");

    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 1, 2, 5, 32'h77, 1, 0, 4, ALU_SLL, 0, 1, 1, 0, 0);
    clock();
    check("sll.src_a", src_a, 32'h1);
    check("sll.src_b", src_b, 32'd4);
    set_id(1, 1, 2, 5, 3, 1, 32'hFFFF_FFF0, 0, ALU_ADD, 1, 0, 1, 0, 0);
    clock();
    check("addi.src_b", src_b, 32'hFFFF_FFF0);
    check("addi.store", ex_store_data, 32'h1);

    // load-use, then stall+flush together yields a bubble
    set_id(1, 1, 2, 8, 0, 0, 4, 0, ALU_ADD, 1, 0, 1, 1, 0);
    clock();
    set_id(1, 8, 2, 9, 0, 0, 0, 0, ALU_ADD, 0, 0, 1, 0, 0);
    #1;
    check("lu.hazard", {31'b0, load_use_hazard}, 32'd1);
    check_all("lu");
    stall = 1; flush = 1;
    clock();
    stall = 0; flush = 0;
    check("lu.valid", {31'b0, ex_valid}, 32'd0);
    check("lu.mr", {31'b0, ex_mem_read}, 32'd0);

    // stall holds everything while decode changes
    set_id(1, 3, 4, 6, 32'h1234, 32'h5678, 0, 0, ALU_SUB, 0, 0, 1, 0, 1);
    clock();
    held_a = src_a; held_b = src_b;
    check("hold.a0", held_a, 32'h1234);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
             5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1, 1, 1);
      clock();
      check("hold.a", src_a, held_a);
      check("hold.b", src_b, held_b);
      check("hold.alu", {27'b0, sig_alu_control}, {27'b0, ALU_SUB});
      check_all("hold");
    end
    reset_pulse("rst_stall");
    stall = 0;

    for (int i = 0; i < 400; i++) begin
      set_id(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
             5'($urandom_range(0, 4)), $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      set_fwd(1'($urandom), 5'($urandom_range(0, 4)), $urandom,
              1'($urandom), 5'($urandom_range(0, 4)), $urandom);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      #1;
      check_all("rnd");
      if ($urandom_range(0, 39) == 0) reset_pulse("rnd_rst");
      clock();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
